// File: rtl/column_matrix_driver.sv
// Double-buffered column capture feeding a row-multiplexed 8xCOLS LED matrix
// through a 74HC595-style chain; the front bank flips only at the frame boundary.
module column_matrix_driver #(
  parameter int COLS     = 32,
  parameter int CLK_DIV  = 2,
  parameter int ROW_HOLD = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] col_in,
  input  logic       col_valid,
  input  logic       frame_sync,
  output logic       sr_data,
  output logic       sr_clk,
  output logic       sr_latch,
  output logic [7:0] row_en,
  output logic       frame_swapped,
  output logic       overrun
);
  localparam int AW   = $clog2(COLS);
  localparam int CMAX = (CLK_DIV > ROW_HOLD) ? CLK_DIV : ROW_HOLD;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {SHIFT, LATCH, HOLD} state_t;

  typedef struct packed {
    state_t          st;
    logic [2:0]      row;
    logic [AW-1:0]   bidx;
    logic [CW-1:0]   cnt;
  } pos_t;

  pos_t          pos, nxt;
  logic          armed, boundary, do_swap;
  logic          fsel, front_valid, nxt_fsel, nxt_fv;
  logic          capturing, swap_pending, completed;
  logic [AW-1:0] wptr, waddr;
  logic          start, wr_en;
  logic [7:0]    rd_col;
  logic [7:0]    bank [2][COLS];

  // Scan position advance; the first edge after reset holds so cycle 0 is bit 0, first half.
  always_comb begin
    nxt      = pos;
    boundary = 1'b0;
    if (armed) begin
      case (pos.st)
        SHIFT: begin
          if (pos.cnt == CW'(CLK_DIV-1)) begin
            nxt.cnt = '0;
            if (pos.bidx == '0) nxt.st = LATCH;
            else                nxt.bidx = pos.bidx - 1'b1;
          end else begin
            nxt.cnt = pos.cnt + 1'b1;
          end
        end
        LATCH: begin
          nxt.st  = HOLD;
          nxt.cnt = '0;
        end
        HOLD: begin
          if (pos.cnt == CW'(ROW_HOLD-1)) begin
            nxt.cnt  = '0;
            nxt.st   = SHIFT;
            nxt.bidx = AW'(COLS-1);
            nxt.row  = pos.row + 3'd1;
            boundary = (pos.row == 3'd7);
          end else begin
            nxt.cnt = pos.cnt + 1'b1;
          end
        end
        default: nxt.st = SHIFT;
      endcase
    end
  end

  assign do_swap  = boundary & swap_pending;
  assign nxt_fsel = fsel ^ do_swap;
  assign nxt_fv   = front_valid | do_swap;
  assign rd_col   = bank[nxt_fsel][nxt.bidx];

  always_ff @(posedge clk) begin
    if (reset) begin
      pos           <= '{st: SHIFT, row: 3'd0, bidx: AW'(COLS-1), cnt: '0};
      armed         <= 1'b0;
      fsel          <= 1'b0;
      front_valid   <= 1'b0;
      sr_data       <= 1'b0;
      sr_clk        <= 1'b0;
      sr_latch      <= 1'b0;
      row_en        <= 8'd0;
      frame_swapped <= 1'b0;
    end else begin
      pos           <= nxt;
      armed         <= 1'b1;
      fsel          <= nxt_fsel;
      front_valid   <= nxt_fv;
      frame_swapped <= do_swap;
      sr_clk        <= (nxt.st == SHIFT) && (nxt.cnt >= CW'(CLK_DIV/2));
      sr_data       <= (nxt.st == SHIFT) && nxt_fv && rd_col[nxt.row];
      sr_latch      <= (nxt.st == LATCH);
      row_en        <= (nxt.st == HOLD) ? (8'd1 << nxt.row) : 8'd0;
    end
  end

  // A frame_sync is ignored while a finished frame waits for the boundary.
  assign start = frame_sync & ~swap_pending;
  assign wr_en = col_valid & (start | capturing);
  assign waddr = start ? '0 : wptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      capturing    <= 1'b0;
      swap_pending <= 1'b0;
      completed    <= 1'b0;
      overrun      <= 1'b0;
      wptr         <= '0;
    end else begin
      if (do_swap) swap_pending <= 1'b0;
      if (start) begin
        capturing <= 1'b1;
        overrun   <= 1'b0;
        wptr      <= col_valid ? AW'(1) : '0;
      end else if (capturing && col_valid) begin
        wptr <= wptr + 1'b1;
        if (wptr == AW'(COLS-1)) begin
          capturing    <= 1'b0;
          swap_pending <= 1'b1;
          completed    <= 1'b1;
        end
      end else if (col_valid && (swap_pending || completed)) begin
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) bank[~fsel][waddr] <= col_in;
  end

endmodule
